// File: rtl/motor_pkg.sv
// Shared types and helpers for the N-channel H-bridge motor controller.
package motor_pkg;

  typedef enum logic [1:0] {StBrake, StFwd, StRev, StDead} mstate_e;

  // Magnitude of a sign-extended command, clamped to 2^(w-1)-1 so the most negative
  // command saturates instead of wrapping to zero.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int unsigned w);
    logic [31:0] mag;
    logic [31:0] pmax;
    mag  = v[31] ? 32'(-v) : 32'(v);
    pmax = (32'd1 << (w - 1)) - 32'd1;
    return (mag > pmax) ? pmax : mag;
  endfunction

endpackage

// File: rtl/motor_chan.sv
// One motor channel: mode FSM, duty and dead-time registers, registered PWM drive.
module motor_chan
  import motor_pkg::*;
#(
  parameter int unsigned DW       = 11,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bnd_i,
  input  logic [DW-2:0]        cnt_nxt_i,
  input  logic signed [DW-1:0] cmd_i,
  output logic                 fwd_o,
  output logic                 rev_o,
  output logic                 dead_o
);

  localparam int unsigned CW = DW - 1;

  mstate_e       state_q, state_d, tgt;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] dead_cnt_q, dead_cnt_d;
  logic [CW-1:0] mag;
  logic          fwd_q, fwd_d, rev_q, rev_d, dead_q, dead_d;

  always_comb begin
    mag = CW'(sat_abs(32'(cmd_i), DW));
    if (cmd_i == '0) begin
      tgt = StBrake;
    end else if (cmd_i[DW-1]) begin
      tgt = StRev;
    end else begin
      tgt = StFwd;
    end

    state_d    = state_q;
    duty_d     = duty_q;
    dead_cnt_d = (dead_cnt_q != '0) ? dead_cnt_q - CW'(1) : dead_cnt_q;
    if (bnd_i) begin
      duty_d = mag;
      case (state_q)
        StFwd:   state_d = (tgt == StRev) ? StDead : tgt;
        StRev:   state_d = (tgt == StFwd) ? StDead : tgt;
        StDead:  state_d = (dead_cnt_q == '0) ? tgt : StDead;
        default: state_d = tgt;
      endcase
      if (state_d == StDead && state_q != StDead) begin
        dead_cnt_d = CW'(DEAD_CYC - 1);
      end
    end

    // Drive values for the next cycle, so a new mode starts exactly at cnt == 0.
    fwd_d  = 1'b0;
    rev_d  = 1'b0;
    dead_d = 1'b0;
    case (state_d)
      StBrake: begin
        fwd_d = 1'b1;
        rev_d = 1'b1;
      end
      StFwd:   fwd_d = (cnt_nxt_i < duty_d);
      StRev:   rev_d = (cnt_nxt_i < duty_d);
      default: dead_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StDead;
      duty_q     <= '0;
      dead_cnt_q <= '0;
      fwd_q      <= 1'b0;
      rev_q      <= 1'b0;
      dead_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dead_cnt_q <= dead_cnt_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      dead_q     <= dead_d;
    end
  end

  assign fwd_o  = fwd_q;
  assign rev_o  = rev_q;
  assign dead_o = dead_q;

endmodule

// File: rtl/motor_cntrl_mc.sv
// N-channel H-bridge motor controller: shared PWM period counter and command register.
module motor_cntrl_mc
  import motor_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DW       = 11,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH*DW-1:0] cmd,
  input  logic                 cmd_vld,
  output logic [NUM_CH-1:0]    fwd,
  output logic [NUM_CH-1:0]    rev,
  output logic [NUM_CH-1:0]    dead
);

  localparam int unsigned CW = DW - 1;
  localparam logic [CW-1:0] PMAX = '1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*DW-1:0] cmd_q, cmd_d;
  logic                 bnd;

  always_comb begin
    bnd   = (cnt_q == PMAX);
    cnt_d = cnt_q + CW'(1);
    cmd_d = cmd_vld ? cmd : cmd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cmd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    motor_chan #(
      .DW       (DW),
      .DEAD_CYC (DEAD_CYC)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .bnd_i     (bnd),
      .cnt_nxt_i (cnt_d),
      .cmd_i     (cmd_q[i*DW +: DW]),
      .fwd_o     (fwd[i]),
      .rev_o     (rev[i]),
      .dead_o    (dead[i])
    );
  end

endmodule

// File: tb/tb_motor_cntrl_mc.sv
// Directed bench for motor_cntrl_mc (NUM_CH=2, DW=11, DEAD_CYC=16, period 1024).
module tb_motor_cntrl_mc;

  localparam int MB = 0;
  localparam int MF = 1;
  localparam int MR = 2;
  localparam int MD = 3;

  logic        clk;
  logic        rst_n;
  logic [21:0] cmd;
  logic        cmd_vld;
  logic [1:0]  fwd, rev, dead;

  int          checks;
  int          errors;
  int          tb_cnt;
  int          m0, d0, m1, d1;
  logic [5:0]  got, exp;

  motor_cntrl_mc #(
    .NUM_CH   (2),
    .DW       (11),
    .DEAD_CYC (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .cmd_vld (cmd_vld),
    .fwd     (fwd),
    .rev     (rev),
    .dead    (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference period counter kept by the bench.
  initial tb_cnt = 0;
  always @(posedge clk) tb_cnt <= (!rst_n) ? 0 : (tb_cnt + 1) % 1024;

  // Expected {fwd, rev, dead} of one channel for a mode, duty and counter value.
  function automatic logic [2:0] exp_ch(input int m, input int duty, input int k);
    case (m)
      MB:      return 3'b110;
      MF:      return {(k < duty), 1'b0, 1'b0};
      MR:      return {1'b0, (k < duty), 1'b0};
      default: return 3'b001;
    endcase
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    cmd     = '0;
    cmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
    checks++;
    if (got !== 6'b001001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", got, 6'b001001);
    end
    rst_n   = 1'b1;
    cmd     = {11'd0, 11'd0};
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    for (int i = 1; i < 2048; i++) begin
      m0 = (i < 1024) ? MD : MB;
      m1 = m0;
      exp = {exp_ch(m1, 0, tb_cnt), exp_ch(m0, 0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_to_brake i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fwd_duty();
    cmd     = {11'd0, 11'd256};
    cmd_vld = 1'b1;
    for (int i = 0; i < 3072; i++) begin
      m0 = (i < 1024) ? MB : MF;
      d0 = 256;
      m1 = MB;
      d1 = 0;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fwd_duty i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
  endtask

  task automatic test_reversal();
    for (int i = 0; i < 4096; i++) begin
      if (i == 500) begin
        cmd     = {11'd0, 11'h600};
        cmd_vld = 1'b1;
      end
      m0 = (i < 1024) ? MF : (i < 2048) ? MD : MR;
      d0 = (i < 1024) ? 256 : 512;
      m1 = MB;
      d1 = 0;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reversal i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5120; i++) begin
      if (i == 0) begin
        cmd     = {11'h400, 11'h600};
        cmd_vld = 1'b1;
      end else if (i == 1029) begin
        cmd     = {11'h3FF, 11'h600};
        cmd_vld = 1'b1;
      end else if (i == 3077) begin
        cmd     = {11'd0, 11'h600};
        cmd_vld = 1'b1;
      end
      m0 = MR;
      d0 = 512;
      m1 = (i < 1024) ? MB : (i < 2048) ? MR : (i < 3072) ? MD : (i < 4096) ? MF : MB;
      d1 = 1023;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturation i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
  endtask

  task automatic test_boundary_load();
    for (int i = 0; i < 6144; i++) begin
      if (i == 0) begin
        cmd     = {11'd0, 11'd100};
        cmd_vld = 1'b1;
      end else if (i == 2048 + 50) begin
        cmd     = {11'd0, 11'd900};
        cmd_vld = 1'b1;
      end else if (i == 3072 + 1023) begin
        cmd     = {11'd0, 11'd300};
        cmd_vld = 1'b1;
      end
      m0 = (i < 1024) ? MR : (i < 2048) ? MD : MF;
      d0 = (i < 1024) ? 512 : (i < 3072) ? 100 : (i < 5120) ? 900 : 300;
      m1 = MB;
      d1 = 0;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL boundary_load i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    cmd     = {11'd0, 11'd512};
    cmd_vld = 1'b1;
    for (int i = 0; i <= 1024 + 300; i++) begin
      m0 = MF;
      d0 = (i < 1024) ? 300 : 512;
      m1 = MB;
      d1 = 0;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_reset i=%0d cnt=%0d got=%b exp=%b", i, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
    // Now in cnt == 301 of the FWD 512 period; reset this cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
    checks++;
    if (got !== 6'b001001) begin
      errors++;
      $display("FAIL mid_reset_state got=%b exp=%b", got, 6'b001001);
    end
    @(negedge clk);
    for (int j = 1; j < 2048; j++) begin
      if (j == 100) begin
        cmd     = {11'd0, 11'd512};
        cmd_vld = 1'b1;
      end
      m0 = (j < 1024) ? MD : MF;
      d0 = 512;
      m1 = (j < 1024) ? MD : MB;
      d1 = 0;
      exp = {exp_ch(m1, d1, tb_cnt), exp_ch(m0, d0, tb_cnt)};
      got = {fwd[1], rev[1], dead[1], fwd[0], rev[0], dead[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset j=%0d cnt=%0d got=%b exp=%b", j, tb_cnt, got, exp);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fwd_duty();
    test_reversal();
    test_saturation();
    test_boundary_load();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
